// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light input conditioner: channel
// indices and the per-channel debounce state encoding.
package tlc_pkg;

    localparam int NUM_CH    = 4;
    localparam int CH_NS_PED = 0;
    localparam int CH_EW_PED = 1;
    localparam int CH_NS_CAR = 2;
    localparam int CH_EW_CAR = 3;

    // S_LO/S_HI are settled levels; CHK_* are "candidate new level" states
    // that must see DEB_CYCLES consecutive agreeing samples to commit.
    typedef enum logic [1:0] {
        S_LO   = 2'd0,
        CHK_HI = 2'd1,
        S_HI   = 2'd2,
        CHK_LO = 2'd3
    } deb_state_e;

endpackage

// File: rtl/tlc_debounce.sv
// Single-channel conditioner: 2-flop synchroniser followed by a
// four-state debounce FSM. Besides the debounced level it exposes the
// level the FSM will hold after the next edge, so the parent can act on
// a debounced edge in the same cycle the level changes.
module tlc_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic clean,
    output logic clean_nxt
);
    import tlc_pkg::*;

    localparam int              CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    deb_state_e       state;
    deb_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Two-flop synchroniser for the asynchronous raw input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce state and stability counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_LO;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: a level change commits only after DEB_CYCLES
    // consecutive synchronised samples at the new level.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_LO: begin
                if (sync_p1) begin
                    if (DEB_CYCLES == 1) begin
                        state_nxt = S_HI;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = CHK_HI;
                        cnt_nxt   = CNT_ONE;
                    end
                end
            end
            CHK_HI: begin
                if (!sync_p1) begin
                    state_nxt = S_LO;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_HI;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            S_HI: begin
                if (!sync_p1) begin
                    if (DEB_CYCLES == 1) begin
                        state_nxt = S_LO;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = CHK_LO;
                        cnt_nxt   = CNT_ONE;
                    end
                end
            end
            CHK_LO: begin
                if (sync_p1) begin
                    state_nxt = S_HI;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_LO;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = S_LO;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Debounced level is high while settled high or checking a fall.
    always_comb begin
        clean     = (state == S_HI) || (state == CHK_LO);
        clean_nxt = (state_nxt == S_HI) || (state_nxt == CHK_LO);
    end

endmodule

// File: rtl/tlc_req_conditioner.sv
// Input conditioner in front of the traffic light controller: debounces
// four raw inputs, latches one pending request per channel until acked,
// and generates the controller's free-running tick.
// Optional stuck-input detection is compiled in with TLC_REQ_STUCK_DET_EN.
module tlc_req_conditioner
    import tlc_pkg::*;
#(
    parameter int DEB_CYCLES   = 4,
    parameter int TICK_DIV     = 10,
    parameter int STUCK_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] btn_raw,
    input  logic [NUM_CH-1:0] ack,
    output logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] btn_clean,
    output logic              tick,
    output logic [NUM_CH-1:0] stuck
);

    localparam int               TCNT_W    = $clog2(TICK_DIV);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TICK_DIV - 1);
    localparam logic [TCNT_W-1:0] TCNT_ONE  = TCNT_W'(1);

    logic [NUM_CH-1:0] btn_clean_nxt;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] req_mask;
    logic [TCNT_W-1:0] tcnt;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_deb
        tlc_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk       (clk),
            .rst       (rst),
            .din       (btn_raw[g]),
            .clean     (btn_clean[g]),
            .clean_nxt (btn_clean_nxt[g])
        );
    end

    // A request is raised by the debounced 0->1 transition only.
    assign rise = btn_clean_nxt & ~btn_clean;

    // Pending-request latch: mask beats set, set beats ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (req_mask[i]) begin
                    req[i] <= 1'b0;
                end else if (rise[i]) begin
                    req[i] <= 1'b1;
                end else if (ack[i]) begin
                    req[i] <= 1'b0;
                end
            end
        end
    end

    // Free-running timebase: tick follows the terminal count by one edge,
    // so the first pulse appears on the TICK_DIV-th edge after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (tcnt == TCNT_LAST);
            if (tcnt == TCNT_LAST) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + TCNT_ONE;
            end
        end
    end

`ifdef TLC_REQ_STUCK_DET_EN
    localparam int               HCNT_W    = $clog2(STUCK_CYCLES + 1);
    localparam logic [HCNT_W-1:0] HCNT_MAX  = HCNT_W'(STUCK_CYCLES);
    localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(STUCK_CYCLES - 1);
    localparam logic [HCNT_W-1:0] HCNT_ONE  = HCNT_W'(1);

    logic [HCNT_W-1:0] hcnt [NUM_CH];
    logic [NUM_CH-1:0] stuck_r;
    logic [NUM_CH-1:0] stuck_hit;

    // Flag the edge on which the high-time count reaches STUCK_CYCLES.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            stuck_hit[i] = btn_clean[i] && btn_clean_nxt[i] && (hcnt[i] == HCNT_LAST);
        end
    end

    // Saturating high-time counter; cleared as the debounced level falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                hcnt[i] <= '0;
            end
            stuck_r <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!btn_clean_nxt[i]) begin
                    hcnt[i]    <= '0;
                    stuck_r[i] <= 1'b0;
                end else if (btn_clean[i] && (hcnt[i] != HCNT_MAX)) begin
                    hcnt[i] <= hcnt[i] + HCNT_ONE;
                    if (stuck_hit[i]) begin
                        stuck_r[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign req_mask = stuck_r | stuck_hit;
    assign stuck    = stuck_r;
`else
    assign req_mask = '0;
    assign stuck    = '0;
`endif

endmodule

// File: tb/tb_tlc_req_conditioner.sv
// Bench for tlc_req_conditioner (DEB_CYCLES=4, TICK_DIV=10).
module tb_tlc_req_conditioner;

    localparam int DEB  = 4;
    localparam int TDIV = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] btn_raw = 4'b0;
    logic [3:0] ack = 4'b0;
    logic [3:0] req;
    logic [3:0] btn_clean;
    logic       tick;
    logic [3:0] stuck;

    tlc_req_conditioner #(
        .DEB_CYCLES   (DEB),
        .TICK_DIV     (TDIV),
        .STUCK_CYCLES (1000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .ack       (ack),
        .req       (req),
        .btn_clean (btn_clean),
        .tick      (tick),
        .stuck     (stuck)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [3:0] btn;
        logic [3:0] ack;
        logic [3:0] clean;
        logic [3:0] req;
    } vec_t;

    vec_t tab [21];

    // Reference model state: raw samples per edge, debounced level, requests.
    logic [3:0] hist [$];
    logic [3:0] m_clean;
    logic [3:0] m_req;
    int         m_edges;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        btn_raw = 4'b0;
        ack     = 4'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic model_reset();
        hist.delete();
        m_clean = 4'b0;
        m_req   = 4'b0;
        m_edges = 0;
    endtask

    // Debounced level flips when the DEB most recent synchronised samples
    // (raw delayed two edges) all disagree with it; requests follow rises.
    task automatic model_edge(input logic [3:0] b, input logic [3:0] a);
        logic [3:0] old_clean;
        logic       flip;
        logic       s;
        int         idx;
        hist.push_back(b);
        if (hist.size() > 32) void'(hist.pop_front());
        m_edges++;
        old_clean = m_clean;
        for (int ch = 0; ch < 4; ch++) begin
            flip = 1'b1;
            for (int j = 0; j < DEB; j++) begin
                idx = hist.size() - 3 - j;
                s   = (idx >= 0) ? hist[idx][ch] : 1'b0;
                if (s == old_clean[ch]) flip = 1'b0;
            end
            if (flip) m_clean[ch] = ~old_clean[ch];
            if (m_clean[ch] && !old_clean[ch]) m_req[ch] = 1'b1;
            else if (a[ch]) m_req[ch] = 1'b0;
        end
    endtask

    initial begin
        // Directed table: edge index relative to the first edge after reset.
        tab[0]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
        tab[1]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0000};
        tab[2]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0000};
        tab[3]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0000};
        tab[4]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
        tab[5]  = '{4'b0001, 4'b0000, 4'b0001, 4'b0001};
        tab[6]  = '{4'b0001, 4'b0001, 4'b0001, 4'b0000};
        tab[7]  = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
        tab[8]  = '{4'b0000, 4'b0000, 4'b0001, 4'b0000};
        tab[9]  = '{4'b0000, 4'b0000, 4'b0001, 4'b0000};
        tab[10] = '{4'b0100, 4'b0000, 4'b0001, 4'b0000};
        tab[11] = '{4'b0100, 4'b0000, 4'b0001, 4'b0000};
        tab[12] = '{4'b0100, 4'b0000, 4'b0001, 4'b0000};
        tab[13] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000};
        tab[14] = '{4'b0101, 4'b0000, 4'b0000, 4'b0000};
        tab[15] = '{4'b0101, 4'b0100, 4'b0100, 4'b0100};
        tab[16] = '{4'b0101, 4'b0001, 4'b0100, 4'b0100};
        tab[17] = '{4'b0101, 4'b0100, 4'b0100, 4'b0000};
        tab[18] = '{4'b0101, 4'b0000, 4'b0100, 4'b0000};
        tab[19] = '{4'b0101, 4'b0000, 4'b0101, 4'b0001};
        tab[20] = '{4'b0101, 4'b0000, 4'b0101, 4'b0001};

        // Reset state and tick cadence.
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", req, 4'b0);
        check("rst_clean", btn_clean, 4'b0);
        check("rst_tick", tick, 1'b0);
        check("rst_stuck", stuck, 4'b0);
        rst = 1'b1;
        for (int n = 1; n <= 35; n++) begin
            step();
            check($sformatf("tick_edge%0d", n), tick, (n % TDIV) == 0);
        end

        // Table-driven debounce / request / ack sequence.
        do_reset();
        for (int i = 0; i < 21; i++) begin
            btn_raw = tab[i].btn;
            ack     = tab[i].ack;
            step();
            check($sformatf("tab%0d_clean", i), btn_clean, tab[i].clean);
            check($sformatf("tab%0d_req", i), req, tab[i].req);
        end
        btn_raw = 4'b0;
        ack     = 4'b0;

        // Reset during a partial debounce with a request pending.
        do_reset();
        btn_raw = 4'b0001;
        repeat (3) step();
        btn_raw = 4'b1001;
        repeat (4) step();
        check("mid_req_pre", req, 4'b0001);
        #2;
        rst = 1'b0;
        #1;
        check("mid_req_rst", req, 4'b0);
        check("mid_clean_rst", btn_clean, 4'b0);
        check("mid_tick_rst", tick, 1'b0);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        btn_raw = 4'b1000;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("mid_clean3_e%0d", k), btn_clean[3], k >= 6);
            check($sformatf("mid_req3_e%0d", k), req[3], k >= 6);
        end

        // Randomised run against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if ($urandom_range(0, 5) == 0) btn_raw[ch] = ~btn_raw[ch];
                ack[ch] = ($urandom_range(0, 3) == 0);
            end
            step();
            model_edge(btn_raw, ack);
            check("rnd_clean", btn_clean, m_clean);
            check("rnd_req", req, m_req);
            check("rnd_tick", tick, (m_edges % TDIV) == 0);
            check("rnd_stuck", stuck, 4'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tlc_req_conditioner.md
Name: tlc_req_conditioner

Overview:
Input-conditioning stage that sits directly upstream of the traffic light controller. It synchronises and debounces raw pedestrian buttons and vehicle sensors, then latches one pending request per channel until the controller acknowledges it. It also generates the controller's timebase tick, so the controller can sequence phases in tick units rather than raw clocks.

Parameters:
DEB_CYCLES, 4, consecutive synchronised cycles an input must hold a new level before the debounced level changes (>=1)
TICK_DIV, 10, clk cycles per tick pulse (>=2)
STUCK_CYCLES, 1000, debounced-high duration that flags a stuck input (used only with the optional feature; > DEB_CYCLES)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (rst=0 resets)
btn_raw  in  4  raw async inputs: [0] NS pedestrian, [1] EW pedestrian, [2] NS car sensor, [3] EW car sensor
ack  in  4  per-channel request clear from controller, one-cycle pulse, synchronous to clk
req  out  4  latched pending request per channel
btn_clean  out  4  debounced level per channel
tick  out  1  one-cycle timebase pulse
stuck  out  4  stuck-input flag per channel (driven 0 when the feature is compiled out)

Behaviour:
- Reset (rst=0, async): all sync flops, debounce counters, btn_clean, req, tick, tick counter and stuck are cleared to 0. Debounce FSMs go to S_LO. Outputs are registered, and nothing changes until the first clk edge after rst rises.
- Synchroniser: 2-flop chain per bit. Call the output sync[i].
- Debounce FSM, one instance per channel, states S_LO, CHK_HI, S_HI, CHK_LO:
  - S_LO: if sync=1, go to CHK_HI with cnt=1. If DEB_CYCLES=1, go straight to S_HI.
  - CHK_HI: if sync=0, return to S_LO with cnt=0. Otherwise cnt++. When cnt reaches DEB_CYCLES, go to S_HI.
  - S_HI and CHK_LO: mirror image of the above.
  - btn_clean=1 in S_HI and CHK_LO. The counter is DEB_CYCLES width-safe via $clog2(DEB_CYCLES+1).
- Latency: the raw edge is first sampled at edge E0. btn_clean changes at edge E0+2+DEB_CYCLES-1 (sync at E0+2, plus DEB_CYCLES stable samples).
- Request latch:
  - On the same edge that btn_clean[i] goes 0→1, req[i] is set to 1.
  - ack[i]=1 clears req[i] on the next edge.
  - If a rise and ack[i] land on the same edge, set wins and req[i] stays 1.
  - ack on a channel that is not pending has no effect.
  - Holding a button does not re-request. Only a new debounced rise sets req.
- Tick:
  - tcnt counts 0..TICK_DIV-1 and wraps.
  - tick is registered and equals 1 for exactly one cycle when tcnt==TICK_DIV-1.
  - The first tick asserts on the TICK_DIV-th edge after reset release, then every TICK_DIV cycles.
  - Tick is free-running and independent of requests.
- Reset mid-operation: any partial debounce or pending request is discarded. Nothing is remembered across reset.

Optional Feature:
Macro: TLC_REQ_STUCK_DET_EN.
- When defined: each channel has a high-time counter that runs while btn_clean[i]=1 and saturates.
  - When the count reaches STUCK_CYCLES, stuck[i] goes to 1 and req[i] is cleared and masked (it cannot set).
  - stuck[i] clears, and masking ends, on the edge btn_clean[i] returns to 0.
- When undefined: no counter logic, and stuck is tied to 4'b0.

Decomposition:
Shared package tlc_pkg contains:
- Channel index constants CH_NS_PED=0, CH_EW_PED=1, CH_NS_CAR=2, CH_EW_CAR=3 and NUM_CH=4.
- The debounce state enum (S_LO, CHK_HI, S_HI, CHK_LO).

One sub-module, tlc_debounce: a single-bit 2-flop synchroniser plus the debounce FSM, generated NUM_CH times. The request latch, tick generator and stuck logic stay in the top.

Test Plan:
(All cases use DEB_CYCLES=4, TICK_DIV=10.)
1. Hold rst=0 for 3 cycles → all outputs 0. Release → tick=1 at edges 10, 20, 30 after release, low otherwise.
2. btn_raw[0]=1 held 20 cycles from edge E0 → btn_clean[0] and req[0] rise at E0+5, no other channel changes.
3. btn_raw[1] high for 3 cycles then low → btn_clean[1] and req[1] stay 0 throughout.
4. After test 2, pulse ack[0] with the button still held → req[0]=0 next edge and stays 0. Release, then press again ≥4 cycles → req[0] returns to 1.
5. Align ack[2] with the edge btn_clean[2] rises → req[2]=1 after that edge.
6. Pull rst=0 during CHK_HI on channel 3 (cnt=2) while req[0]=1 → req, btn_clean and tick are 0 immediately. After release, btn_raw[3] needs the full 2+4 cycles again.
